if_stage_skid_reg: RTL and testbench

Parametrised IF→ID pipeline register that replaces the single-entry freeze/flush register with a small elastic buffer. It accepts fetched PC/instruction pairs with a valid/ready handshake and queues up to `DEPTH` entries. It drives the head entry to the decode stage and supports global freeze and flush. It sits between the instruction-fetch stage and the decode stage and is a drop-in successor for the fetch-stage pipeline register.

---
 rtl/if_stage_skid_reg.sv | 121 ++++++++++++
 tb/tb_if_stage_skid_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_stage_skid_reg.sv
// IF->ID elastic pipeline register: DEPTH-entry circular buffer with valid/ready, freeze and flush.
// Optional performance counters are compiled in when IF_REG_PERF_CNT_EN is defined.
module if_stage_skid_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               freeze,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [2:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [2:0]         count_r;
  logic               push_s;
  logic               pop_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] head_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Handshake and head presentation; the head reads as a NOP bubble while empty.
  always_comb begin
    empty_s   = (count_r == 3'd0);
    in_ready  = !freeze && !flush && ((count_r < DEPTH_C) || out_ready);
    out_valid = !empty_s && !freeze && !flush;
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    head_s    = mem_r[rd_ptr_r];
    if (empty_s) begin
      pc_out          = {ADDR_W{1'b0}};
      instruction_out = {INSTR_W{1'b0}};
    end else begin
      pc_out          = head_s[ENTRY_W-1:INSTR_W];
      instruction_out = head_s[INSTR_W-1:0];
    end
  end

  assign occupancy = count_r;

  // Buffer storage, pointers and fill count; freeze needs no branch since it gates push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r  <= 3'd0;
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (flush) begin
      count_r  <= 3'd0;
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {pc_in, instruction_in};
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef IF_REG_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             stall_ev_s;

  assign stall_ev_s = freeze || (out_valid && !out_ready);

  // Saturating stall/flush counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_ev_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_stage_skid_reg.sv
// Randomized bench for if_stage_skid_reg against a queue-based reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_if_stage_skid_reg;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, freeze, flush, out_valid, out_ready;
  logic [31:0] pc_in, instruction_in, pc_out, instruction_out;
  logic [2:0]  occupancy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] q[$];
  int  m_stall = 0;
  int  m_flush = 0;
  bit  known   = 1'b0;

  if_stage_skid_reg #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in), .freeze(freeze), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .instruction_out(instruction_out), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model for the inputs currently applied.
  task automatic check_model();
    bit          e_ir, e_ov;
    logic [63:0] head;
    int          e_sc, e_fc;
    head = (q.size() != 0) ? q[0] : 64'd0;
    e_ir = !freeze && !flush && ((q.size() < DEPTH) || out_ready);
    e_ov = (q.size() != 0) && !freeze && !flush;
`ifdef IF_REG_PERF_CNT_EN
    e_sc = m_stall;
    e_fc = m_flush;
`else
    e_sc = 0;
    e_fc = 0;
`endif
    cmp("in_ready",  {63'd0, in_ready},  {63'd0, e_ir});
    cmp("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    cmp("pc_out",    {32'd0, pc_out},    {32'd0, head[63:32]});
    cmp("instr_out", {32'd0, instruction_out}, {32'd0, head[31:0]});
    cmp("occupancy", {61'd0, occupancy}, 64'(q.size()));
    cmp("stall_cnt", {60'd0, stall_cnt}, 64'(e_sc));
    cmp("flush_cnt", {60'd0, flush_cnt}, 64'(e_fc));
  endtask

  // Apply the effect of the coming clock edge to the model.
  task automatic model_next();
    bit e_ir, e_ov;
    e_ir = !freeze && !flush && ((q.size() < DEPTH) || out_ready);
    e_ov = (q.size() != 0) && !freeze && !flush;
    if (!rst) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
      known   = 1'b1;
    end else begin
      if (freeze || (e_ov && !out_ready)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (flush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (flush) begin
        q.delete();
      end else begin
        if (e_ov && out_ready) void'(q.pop_front());
        if (e_ir && in_valid) q.push_back({pc_in, instruction_in});
      end
    end
  endtask

  task automatic step(input bit r, input bit iv, input bit fr, input bit fl, input bit ordy,
                      input logic [31:0] pc);
    rst = r; in_valid = iv; freeze = fr; flush = fl; out_ready = ordy;
    pc_in = pc; instruction_in = pc ^ 32'hA5A5_0000;
    #3;
    if (known) check_model();
    model_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in = 32'd0; instruction_in = 32'd0;
    @(posedge clk);
    #1;

    // Reset then idle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1; #1;
    cmp("rst_out_valid", {63'd0, out_valid}, 64'd0);
    cmp("rst_pc_out", {32'd0, pc_out}, 64'd0);
    cmp("rst_instr_out", {32'd0, instruction_out}, 64'd0);
    cmp("rst_occupancy", {61'd0, occupancy}, 64'd0);
    cmp("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming with out_ready held high
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
    cmp("stream_pc_4", {32'd0, pc_out}, 64'h4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
    cmp("stream_pc_8", {32'd0, pc_out}, 64'h8);
    cmp("stream_occ", {61'd0, occupancy}, 64'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC);
    cmp("stream_pc_c", {32'd0, pc_out}, 64'hC);
    cmp("stream_instr_c", {32'd0, instruction_out}, 64'hA5A5_000C);

    // Backpressure to full, then simultaneous pop/push
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8);
    cmp("full_occ", {61'd0, occupancy}, 64'd2);
    cmp("full_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC);
    cmp("swap_occ", {61'd0, occupancy}, 64'd2);
    cmp("swap_head", {32'd0, pc_out}, 64'h8);

    // Freeze a full buffer for three cycles
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h24);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h28);
    out_ready = 1'b0; in_valid = 1'b0; #1;
    cmp("frz_occ", {61'd0, occupancy}, 64'd2);
    cmp("frz_in_ready", {63'd0, in_ready}, 64'd0);
    cmp("frz_out_valid", {63'd0, out_valid}, 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cmp("frz_release_pc", {32'd0, pc_out}, 64'h8);

    // Flush together with freeze and a push
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10);
    cmp("flush_occ", {61'd0, occupancy}, 64'd0);
    cmp("flush_instr", {32'd0, instruction_out}, 64'd0);
`ifdef IF_REG_PERF_CNT_EN
    cmp("flush_cnt_1", {60'd0, flush_cnt}, 64'd1);
`else
    cmp("flush_cnt_0", {60'd0, flush_cnt}, 64'd0);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cmp("flush_no_0x10", {32'd0, pc_out}, 64'd0);

    // Stall counter saturation
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IF_REG_PERF_CNT_EN
    cmp("stall_sat", {60'd0, stall_cnt}, 64'd15);
`else
    cmp("stall_off", {60'd0, stall_cnt}, 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 6),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
